// File: rtl/spi_bridge_pkg.sv
// Shared SPI<->AHB bridge definitions: FSM state encoding and default sizing,
// used by both the RX drain controller and the TX-side controller.
package spi_bridge_pkg;

    localparam int unsigned SPI_DATA_WIDTH  = 32;
    localparam int unsigned SPI_CNT_W       = 16;
    localparam int unsigned SPI_TIMEOUT_CYC = 256;
    localparam int unsigned SPI_STATE_W     = 3;

    typedef enum logic [SPI_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_FLUSH = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_rx_timeout_cnt.sv
// Unacked-hold watchdog: counts HOLD cycles without an ack and raises a sticky flag.
// Only built with RX_TIMEOUT_EN defined.
`ifdef RX_TIMEOUT_EN
module spi_rx_timeout_cnt
    import spi_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = SPI_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic ack,
    input  logic flush,
    output logic timeout
);

    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             clr_c;
    logic             idle_hold_c;

    assign clr_c       = flush | (hold & ack);
    assign idle_hold_c = hold & ~ack & ~flush;

    // Counter parks at its last value once the flag is set, so the flag stays sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else if (clr_c) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else if (idle_hold_c) begin
            if (tmo_cnt == TMO_LAST) begin
                timeout <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/spi_rx_drain_ctrl.sv
// HCLK-side drain controller for the SPI->AHB RX FIFO: pops one word at a time into a
// holding register with valid/ack delivery, counts delivered words, flush and IRQ.
// Optional unacked-hold watchdog enabled by defining RX_TIMEOUT_EN.
module spi_rx_drain_ctrl
    import spi_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int unsigned CNT_W       = SPI_CNT_W
`ifdef RX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = SPI_TIMEOUT_CYC
`endif
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  ctrl_en,
    input  logic                  flush,
    input  logic                  irq_en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic [CNT_W-1:0]      rx_count,
    output logic                  rx_timeout,
    output logic                  rx_irq
);

    spi_state_e state_q;
    spi_state_e state_d;
    logic       flush_seen_q;
    logic       load_c;
    logic       valid_set_c;
    logic       deliver_c;
    logic       drop_c;

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (ctrl_en && !fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = (flush || flush_seen_q) ? ST_FLUSH : ST_HOLD;
            ST_HOLD: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                end else if (rx_ack) begin
                    state_d = (ctrl_en && !fifo_empty) ? ST_FETCH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (fifo_empty && !flush) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded strobes; flush beats a same-cycle ack in HOLD
    always_comb begin
        fifo_rd_en  = 1'b0;
        load_c      = 1'b0;
        valid_set_c = 1'b0;
        deliver_c   = 1'b0;
        drop_c      = 1'b0;
        case (state_q)
            ST_FETCH: fifo_rd_en = 1'b1;
            ST_LOAD: begin
                load_c      = 1'b1;
                valid_set_c = ~(flush | flush_seen_q);
            end
            ST_HOLD: begin
                drop_c    = flush;
                deliver_c = rx_ack & ~flush;
            end
            ST_FLUSH: begin
                fifo_rd_en = ~fifo_empty;
                drop_c     = 1'b1;
            end
            default: ;
        endcase
    end

    // Holding register, valid flag and delivered-word counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            flush_seen_q <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_count     <= '0;
        end else begin
            flush_seen_q <= (state_q == ST_FETCH) && flush;
            if (load_c) begin
                rx_data <= fifo_rd_data;
            end
            if (valid_set_c) begin
                rx_valid <= 1'b1;
            end else if (deliver_c || drop_c) begin
                rx_valid <= 1'b0;
            end
            if (deliver_c) begin
                rx_count <= rx_count + CNT_W'(1);
            end
        end
    end

`ifdef RX_TIMEOUT_EN
    spi_rx_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .hold    (state_q == ST_HOLD),
        .ack     (rx_ack),
        .flush   (flush),
        .timeout (rx_timeout)
    );
`else
    assign rx_timeout = 1'b0;
`endif

    assign rx_irq = irq_en & (rx_valid | rx_timeout);

endmodule

// File: tb/tb_spi_rx_drain_ctrl.sv
// Directed bench for spi_rx_drain_ctrl: vector table for steady delivery plus hand
// sequences for reset, timeout, flush, ctrl_en gating and counter wrap.
module tb_spi_rx_drain_ctrl;

`ifdef RX_TIMEOUT_EN
    localparam logic TMO_ON = 1'b1;
`else
    localparam logic TMO_ON = 1'b0;
`endif

    logic        HCLK;
    logic        HRESETn;
    logic        ctrl_en;
    logic        flush;
    logic        irq_en;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic [15:0] rx_count;
    logic        rx_timeout;
    logic        rx_irq;

    logic        w_rd_en;
    logic [31:0] w_data;
    logic        w_valid;
    logic [3:0]  w_count;
    logic        w_timeout;
    logic        w_irq;

    int n_cmp = 0;
    int n_err = 0;

    // FIFO model: data appears the cycle after a pop
    logic [31:0] fifo_mem [16];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int stale_pops = 0;

    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge HCLK) begin
        if (fifo_rd_en) begin
            if (wr_cnt != rd_cnt) begin
                fifo_rd_data <= fifo_mem[rd_cnt % 16];
                rd_cnt       <= rd_cnt + 1;
            end else begin
                stale_pops <= stale_pops + 1;
            end
        end
    end

    spi_rx_drain_ctrl dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .ctrl_en      (ctrl_en),
        .flush        (flush),
        .irq_en       (irq_en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ack       (rx_ack),
        .rx_count     (rx_count),
        .rx_timeout   (rx_timeout),
        .rx_irq       (rx_irq)
    );

    // Narrow-counter instance that streams continuously, to reach the wrap point quickly
    spi_rx_drain_ctrl #(.CNT_W(4)) dut_wrap (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .ctrl_en      (1'b1),
        .flush        (1'b0),
        .irq_en       (1'b0),
        .fifo_empty   (1'b0),
        .fifo_rd_en   (w_rd_en),
        .fifo_rd_data (32'hC0DE_0000),
        .rx_data      (w_data),
        .rx_valid     (w_valid),
        .rx_ack       (1'b1),
        .rx_count     (w_count),
        .rx_timeout   (w_timeout),
        .rx_irq       (w_irq)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    typedef struct {
        logic        ctrl_en;
        logic        flush;
        logic        irq_en;
        logic        ack;
        logic        exp_rd_en;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [15:0] exp_count;
        logic        exp_irq;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        fifo_mem[wr_cnt % 16] = d;
        wr_cnt = wr_cnt + 1;
    endtask

    // Expects IDLE with exactly one word queued and ctrl_en high
    task automatic get_word(input string name, input logic [31:0] d);
        tick();
        tick();
        chk({name, " valid_pre"}, 32'(rx_valid), 32'd0);
        tick();
        chk({name, " valid"}, 32'(rx_valid), 32'd1);
        chk({name, " data"}, rx_data, d);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        chk({name, " valid_clr"}, 32'(rx_valid), 32'd0);
    endtask

    initial begin
        logic saw;
        int   guard;

        HRESETn = 1'b0;
        ctrl_en = 1'b0;
        flush   = 1'b0;
        irq_en  = 1'b0;
        rx_ack  = 1'b0;
        fifo_rd_data = 32'h0;

        //                 ctl flu irq ack  rd  val data           cnt    irq
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,          16'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,          16'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001,  16'd0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          16'd1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,          16'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0002,  16'd1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,          16'd2, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,          16'd2, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0003,  16'd2, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,          16'd3, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,          16'd3, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,          16'd3, 1'b0};

        // Reset state
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst rx_valid", 32'(rx_valid), 32'd0);
        chk("rst rx_count", 32'(rx_count), 32'd0);
        chk("rst rx_data", rx_data, 32'd0);
        chk("rst rd_en", 32'(fifo_rd_en), 32'd0);
        HRESETn = 1'b1;
        tick();
        chk("idle rd_en", 32'(fifo_rd_en), 32'd0);

        // Three queued words delivered back to back
        push(32'hA5A5_0001);
        push(32'hA5A5_0002);
        push(32'hA5A5_0003);
        for (int i = 0; i < NV; i++) begin
            ctrl_en = vecs[i].ctrl_en;
            flush   = vecs[i].flush;
            irq_en  = vecs[i].irq_en;
            rx_ack  = vecs[i].ack;
            tick();
            chk($sformatf("vec%0d rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].exp_rd_en));
            chk($sformatf("vec%0d valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d count", i), 32'(rx_count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d irq", i), 32'(rx_irq), 32'(vecs[i].exp_irq));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d data", i), rx_data, vecs[i].exp_data);
            end
        end
        rx_ack = 1'b0;
        chk("vec pops", 32'(rd_cnt), 32'd3);

        // Reset asserted while a word is held and rx_count is 5
        ctrl_en = 1'b1;
        push(32'h0000_0004);
        get_word("w4", 32'h0000_0004);
        push(32'h0000_0005);
        get_word("w5", 32'h0000_0005);
        push(32'h0000_0006);
        repeat (3) tick();
        chk("pre-rst valid", 32'(rx_valid), 32'd1);
        chk("pre-rst count", 32'(rx_count), 32'd5);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst rx_valid", 32'(rx_valid), 32'd0);
        chk("arst rx_count", 32'(rx_count), 32'd0);
        chk("arst rx_data", rx_data, 32'd0);
        chk("arst rx_timeout", 32'(rx_timeout), 32'd0);
        chk("arst rd_en", 32'(fifo_rd_en), 32'd0);
        chk("arst rx_irq", 32'(rx_irq), 32'd0);
        tick();
        HRESETn = 1'b1;
        tick();
        chk("post-rst rd_en", 32'(fifo_rd_en), 32'd0);
        chk("post-rst valid", 32'(rx_valid), 32'd0);

        // Held word left unacked: latency 3 cycles, then watchdog
        push(32'h1234_5678);
        tick();
        chk("tmo fetch rd_en", 32'(fifo_rd_en), 32'd1);
        tick();
        chk("tmo load valid", 32'(rx_valid), 32'd0);
        tick();
        chk("tmo hold valid", 32'(rx_valid), 32'd1);
        chk("tmo hold data", rx_data, 32'h1234_5678);
        repeat (255) tick();
        chk("tmo at 255", 32'(rx_timeout), 32'd0);
        tick();
        chk("tmo at 256", 32'(rx_timeout), 32'(TMO_ON));
        chk("tmo irq", 32'(rx_irq), 32'd1);
        repeat (44) tick();
        chk("tmo sticky", 32'(rx_timeout), 32'(TMO_ON));
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        chk("tmo ack clr", 32'(rx_timeout), 32'd0);
        chk("tmo ack valid", 32'(rx_valid), 32'd0);
        chk("tmo ack count", 32'(rx_count), 32'd1);

        // flush and rx_ack together in HOLD: flush wins
        push(32'h5555_AAAA);
        repeat (3) tick();
        chk("fa hold valid", 32'(rx_valid), 32'd1);
        flush  = 1'b1;
        rx_ack = 1'b1;
        tick();
        flush  = 1'b0;
        rx_ack = 1'b0;
        chk("fa valid", 32'(rx_valid), 32'd0);
        chk("fa count", 32'(rx_count), 32'd1);
        chk("fa rd_en", 32'(fifo_rd_en), 32'd0);
        tick();

        // Flush raised in LOAD with four words queued
        for (int i = 0; i < 4; i++) push(32'hF000_0000 + 32'(i));
        tick();
        tick();
        flush = 1'b1;
        tick();
        chk("fl rd_en", 32'(fifo_rd_en), 32'd1);
        saw   = 1'b0;
        guard = 0;
        while (!fifo_empty && guard < 8) begin
            tick();
            saw = saw | rx_valid;
            guard++;
        end
        chk("fl drained", 32'(fifo_empty), 32'd1);
        flush = 1'b0;
        tick();
        saw = saw | rx_valid;
        chk("fl valid seen", 32'(saw), 32'd0);
        chk("fl count", 32'(rx_count), 32'd1);
        tick();
        chk("fl idle rd_en", 32'(fifo_rd_en), 32'd0);
        chk("fl stale", 32'(stale_pops), 32'd0);

        // ctrl_en gating, and ctrl_en dropped mid-word
        ctrl_en = 1'b0;
        push(32'h6666_0001);
        push(32'h6666_0002);
        saw = 1'b0;
        repeat (20) begin
            tick();
            saw = saw | fifo_rd_en;
        end
        chk("gate no pop", 32'(saw), 32'd0);
        ctrl_en = 1'b1;
        #1;
        chk("gate idle rd_en", 32'(fifo_rd_en), 32'd0);
        tick();
        chk("gate first pop", 32'(fifo_rd_en), 32'd1);
        ctrl_en = 1'b0;
        tick();
        chk("gate load rd_en", 32'(fifo_rd_en), 32'd0);
        tick();
        chk("gate hold valid", 32'(rx_valid), 32'd1);
        chk("gate hold data", rx_data, 32'h6666_0001);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        chk("gate count", 32'(rx_count), 32'd2);
        saw = fifo_rd_en;
        repeat (5) begin
            tick();
            saw = saw | fifo_rd_en;
        end
        chk("gate no refetch", 32'(saw), 32'd0);
        ctrl_en = 1'b1;
        get_word("w62", 32'h6666_0002);
        chk("gate final count", 32'(rx_count), 32'd3);
        chk("stale pops", 32'(stale_pops), 32'd0);

        // Counter wrap from all-ones to zero on the narrow instance
        guard = 0;
        while (w_count != 4'hF && guard < 100) begin
            tick();
            guard++;
        end
        chk("wrap reach max", 32'(w_count), 32'hF);
        guard = 0;
        while (w_count == 4'hF && guard < 6) begin
            tick();
            guard++;
        end
        chk("wrap count", 32'(w_count), 32'h0);
        chk("wrap rd_en", 32'(w_rd_en), 32'd1);
        chk("wrap valid", 32'(w_valid), 32'd0);
        chk("wrap data", w_data, 32'hC0DE_0000);
        chk("wrap timeout", 32'(w_timeout), 32'd0);
        chk("wrap irq", 32'(w_irq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
